intlv_pp_ctrl: RTL and testbench
================================

# intlv_pp_ctrl

Ping-pong bank controller for the HPGP turbo interleaver RAM. Accepts PB requests of type PB16/PB136/PB520, writes the incoming bit stream into one of two RAM banks, and hands completed banks to the interleaved-read address generator. Write and read proceed on opposite banks. The block sits between the PB framer (upstream) and the read address generator / RAM (downstream).

## Interface
- ADDRESS, 12, RAM address width inside one bank
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  PB request; accepted when start && start_rdy
- pb_type  in  2  0=PB16, 1=PB136, 2=PB520, 3=illegal; sampled on accept
- start_rdy  out  1  a write can be accepted this cycle
- din_vld  in  1  one input bit valid this cycle
- wen  out  1  RAM write enable, registered
- wr_addr  out  ADDRESS  RAM write address within bank, registered
- wr_bank  out  1  bank being written, registered
- rd_start  out  1  one-cycle pulse: read address generator starts on rd_bank
- rd_len  out  ADDRESS  PB length for the read, held from rd_start until rd_done
- rd_offset  out  ADDRESS  PB offset for the read, held likewise
- rd_bank  out  1  bank being read
- rd_done  in  1  one-cycle pulse: read of rd_bank finished
- busy  out  1  any bank not EMPTY, or write FSM not W_IDLE
- err  out  1  sticky error flag (see Configuration)

## Operation
- Lengths/offsets: PB16 = 12'h040 / 12'h000; PB136 = 12'h220 / 12'h040; PB520 = 12'h820 / 12'h260.
- Per-bank state: EMPTY, FILLING, FULL, DRAINING. Per-bank len and offset registers are latched on accept.
- Write FSM W_IDLE/W_FILL, pointer wr_ptr:
  - start_rdy = (W_IDLE && bank[wr_ptr]==EMPTY), combinational from registers.
  - On accept: bank[wr_ptr] becomes FILLING, w_cnt=0, go to W_FILL.
  - In W_FILL, each din_vld writes address w_cnt and increments w_cnt (12-bit, no wrap needed; max 2079).
  - On din_vld with w_cnt==len-1: bank becomes FULL, wr_ptr toggles, go to W_IDLE.
  - din_vld outside W_FILL is ignored; it generates no wen.
- Read FSM R_IDLE/R_RUN, pointer rd_ptr:
  - In R_IDLE with bank[rd_ptr]==FULL: register rd_start=1, rd_bank=rd_ptr, rd_len, rd_offset; bank becomes DRAINING; go to R_RUN.
  - In R_RUN, rd_done sets the bank to EMPTY, toggles rd_ptr, and returns to R_IDLE.
  - rd_done in R_IDLE is ignored.
- Simultaneous events:
  - Write completion and rd_done in the same cycle touch different banks; both take effect.
  - start is evaluated against the pre-edge bank state, so a bank freed at edge N is accepted at the earliest in cycle N+1.
- Reset, including mid-PB: both banks EMPTY, both pointers 0, both FSMs idle, in-flight PB discarded.

## Timing
- Reset values: start_rdy=1 (derived), wen=0, wr_addr=0, wr_bank=0, rd_start=0, rd_len=0, rd_offset=0, rd_bank=0, busy=0, err=0.
- Write latency: din_vld in cycle N gives wen/wr_addr/wr_bank valid in cycle N+1.
- Read handoff:
  - The last din_vld in cycle N makes the bank FULL after edge N.
  - rd_start is high in cycle N+2 if the read FSM is idle.
- Throughput: one bit per cycle. A back-to-back PB can start the cycle after the last bit if the other bank is EMPTY.

## Configuration
- INTLV_ERR_CHK_EN defined:
  - err sets (sticky until reset) on accepted pb_type==3 (request dropped, no bank claimed), on din_vld outside W_FILL, and on rd_done in R_IDLE.
- INTLV_ERR_CHK_EN undefined:
  - err tied 0.
  - pb_type==3 decodes as PB16.
  - Stray din_vld and rd_done are silently ignored.

## Structure
- Package intlv_pkg holds:
  - PB type encodings.
  - Length constants 12'h040/12'h220/12'h820 and offset constants 12'h000/12'h040/12'h260.
  - Bank-state and FSM state encodings.
- Sub-module intlv_wr_seq contains the write FSM, w_cnt, and the registered wen/wr_addr/wr_bank. The top level holds the bank state, the read FSM and the error logic.

## Test plan
- Single PB16, din_vld continuous for 64 cycles:
  - wr_addr sequences 0..63 on bank 0.
  - rd_start pulses once, 2 cycles after the last din_vld, with rd_len=12'h040, rd_offset=0, rd_bank=0.
- PB136 then PB520 back-to-back, no rd_done:
  - Bank 1 fills and start_rdy stays 0 afterwards.
  - rd_done on bank 0 raises start_rdy the next cycle.
- Gapped din_vld (1-in-3) on PB136: exactly 544 wen pulses, addresses contiguous 0..543.
- rd_done in the same cycle as the last PB bit into the other bank:
  - Both banks update.
  - rd_start for the new bank follows within 2 cycles.
- pb_type=3 with the macro defined: err=1 and no bank claimed. Without the macro: treated as a 64-bit PB.
- Reset asserted at bit 300 of a PB520: all outputs return to reset values and a new PB16 proceeds normally on bank 0.

Source files
------------

// File: rtl/intlv_pkg.sv
// intlv_pkg: shared types and constants for the HPGP turbo interleaver
// ping-pong bank controller (PB encodings, PB geometry, FSM/bank states).
package intlv_pkg;

   localparam int ADDRESS = 12;

   typedef enum logic [1:0] {
      PB16       = 2'd0,
      PB136      = 2'd1,
      PB520      = 2'd2,
      PB_ILLEGAL = 2'd3
   } pb_type_e;

   localparam logic [ADDRESS-1:0] LEN_PB16  = 12'h040;
   localparam logic [ADDRESS-1:0] LEN_PB136 = 12'h220;
   localparam logic [ADDRESS-1:0] LEN_PB520 = 12'h820;
   localparam logic [ADDRESS-1:0] OFF_PB16  = 12'h000;
   localparam logic [ADDRESS-1:0] OFF_PB136 = 12'h040;
   localparam logic [ADDRESS-1:0] OFF_PB520 = 12'h260;

   typedef enum logic [1:0] {
      B_EMPTY,
      B_FILLING,
      B_FULL,
      B_DRAINING
   } bank_state_e;

   typedef enum logic {W_IDLE, W_FILL} wr_state_e;
   typedef enum logic {R_IDLE, R_RUN}  rd_state_e;

   // Length/offset pair latched per bank and handed to the reader.
   typedef struct packed {
      logic [ADDRESS-1:0] len;
      logic [ADDRESS-1:0] offset;
   } pb_geom_t;

   // PB geometry lookup; the illegal code falls back to PB16 geometry.
   function automatic pb_geom_t pb_geom(input pb_type_e t);
      pb_geom_t g;
      case (t)
         PB136:   begin g.len = LEN_PB136; g.offset = OFF_PB136; end
         PB520:   begin g.len = LEN_PB520; g.offset = OFF_PB520; end
         default: begin g.len = LEN_PB16;  g.offset = OFF_PB16;  end
      endcase
      return g;
   endfunction

endpackage

// File: rtl/intlv_wr_seq.sv
// intlv_wr_seq: write sequencer. Fills the bank selected by wr_ptr one bit per
// din_vld, produces the registered RAM write port and flags the last bit.
module intlv_wr_seq
   import intlv_pkg::*;
(
   input  logic               clk,
   input  logic               n_rst,
   input  logic               accept_i,
   input  logic               din_vld_i,
   input  logic [ADDRESS-1:0] len_i,
   output logic               w_idle_o,
   output logic               wr_ptr_o,
   output logic               fill_done_o,
   output logic               wen_o,
   output logic [ADDRESS-1:0] wr_addr_o,
   output logic               wr_bank_o
);

   wr_state_e          state_q, state_d;
   logic [ADDRESS-1:0] w_cnt_q, w_cnt_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic               wen_q;
   logic [ADDRESS-1:0] wr_addr_q;
   logic               wr_bank_q;
   logic               bit_fire;
   logic               last_bit;

   // Write FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!n_rst) state_q <= W_IDLE;
      else        state_q <= state_d;
   end

   // Write FSM next state: idle until a PB is accepted, fill until its last bit.
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         W_IDLE:  if (accept_i) state_d = W_FILL;
         W_FILL:  if (last_bit) state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
   end

   // Write FSM outputs: a bit is written only while filling.
   always_comb begin
      bit_fire = (state_q == W_FILL) && din_vld_i;
      last_bit = bit_fire && (w_cnt_q == len_i - ADDRESS'(1));
   end

   // Counter and bank pointer next values.
   always_comb begin
      w_cnt_d  = w_cnt_q;
      wr_ptr_d = wr_ptr_q;
      if ((state_q == W_IDLE) && accept_i) w_cnt_d = '0;
      else if (bit_fire)                   w_cnt_d = w_cnt_q + ADDRESS'(1);
      if (last_bit) wr_ptr_d = ~wr_ptr_q;
   end

   // Counter, pointer and registered RAM write port.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         w_cnt_q   <= '0;
         wr_ptr_q  <= 1'b0;
         wen_q     <= 1'b0;
         wr_addr_q <= '0;
         wr_bank_q <= 1'b0;
      end else begin
         w_cnt_q  <= w_cnt_d;
         wr_ptr_q <= wr_ptr_d;
         wen_q    <= bit_fire;
         if (bit_fire) begin
            wr_addr_q <= w_cnt_q;
            wr_bank_q <= wr_ptr_q;
         end
      end
   end

   assign w_idle_o    = (state_q == W_IDLE);
   assign wr_ptr_o    = wr_ptr_q;
   assign fill_done_o = last_bit;
   assign wen_o       = wen_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_bank_o   = wr_bank_q;

endmodule

// File: rtl/intlv_pp_ctrl.sv
// intlv_pp_ctrl: ping-pong bank controller for the turbo interleaver RAM.
// Holds per-bank state and geometry, the read hand-off FSM and error flag.
// Optional error checking is enabled by defining INTLV_ERR_CHK_EN.
module intlv_pp_ctrl
   import intlv_pkg::*;
(
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic [1:0]         pb_type,
   output logic               start_rdy,
   input  logic               din_vld,
   output logic               wen,
   output logic [ADDRESS-1:0] wr_addr,
   output logic               wr_bank,
   output logic               rd_start,
   output logic [ADDRESS-1:0] rd_len,
   output logic [ADDRESS-1:0] rd_offset,
   output logic               rd_bank,
   input  logic               rd_done,
   output logic               busy,
   output logic               err
);

   bank_state_e bank_q [2];
   bank_state_e bank_d [2];
   pb_geom_t    geom_q [2];
   rd_state_e   rd_state_q, rd_state_d;
   logic        rd_ptr_q;
   logic        rd_start_q;
   logic        rd_bank_q;
   pb_geom_t    rd_geom_q;
   logic        w_idle, wr_ptr, fill_done;
   logic        take, claim, launch, drain_end;

   intlv_wr_seq u_wr_seq (
      .clk         (clk),
      .n_rst       (n_rst),
      .accept_i    (claim),
      .din_vld_i   (din_vld),
      .len_i       (geom_q[wr_ptr].len),
      .w_idle_o    (w_idle),
      .wr_ptr_o    (wr_ptr),
      .fill_done_o (fill_done),
      .wen_o       (wen),
      .wr_addr_o   (wr_addr),
      .wr_bank_o   (wr_bank)
   );

   assign start_rdy = w_idle && (bank_q[wr_ptr] == B_EMPTY);
   assign take      = start && start_rdy;

`ifdef INTLV_ERR_CHK_EN
   logic err_q;

   // An illegal PB type is accepted but dropped: it claims no bank.
   assign claim = take && (pb_type_e'(pb_type) != PB_ILLEGAL);

   // Sticky error capture: illegal request, stray bit, stray read completion.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) err_q <= 1'b0;
      else if ((take && (pb_type_e'(pb_type) == PB_ILLEGAL)) ||
               (din_vld && w_idle) ||
               (rd_done && (rd_state_q == R_IDLE)))
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign claim = take;
   assign err   = 1'b0;
`endif

   // Bank state transitions; the four events need distinct current states,
   // so at most one of them touches a given bank in any cycle.
   always_comb begin
      bank_d = bank_q;
      if (claim)     bank_d[wr_ptr]   = B_FILLING;
      if (fill_done) bank_d[wr_ptr]   = B_FULL;
      if (launch)    bank_d[rd_ptr_q] = B_DRAINING;
      if (drain_end) bank_d[rd_ptr_q] = B_EMPTY;
   end

   // Bank state and per-bank geometry registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int b = 0; b < 2; b++) begin
            bank_q[b] <= B_EMPTY;
            geom_q[b] <= '0;
         end
      end else begin
         bank_q <= bank_d;
         if (claim) geom_q[wr_ptr] <= pb_geom(pb_type_e'(pb_type));
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) rd_state_q <= R_IDLE;
      else        rd_state_q <= rd_state_d;
   end

   // Read FSM next state: launch on a full bank, wait for its completion.
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         R_IDLE:  if (bank_q[rd_ptr_q] == B_FULL) rd_state_d = R_RUN;
         R_RUN:   if (rd_done)                    rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read FSM outputs: launch and completion strobes.
   always_comb begin
      launch    = (rd_state_q == R_IDLE) && (bank_q[rd_ptr_q] == B_FULL);
      drain_end = (rd_state_q == R_RUN) && rd_done;
   end

   // Read pointer and registered hand-off to the address generator.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_ptr_q   <= 1'b0;
         rd_start_q <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_geom_q  <= '0;
      end else begin
         rd_start_q <= launch;
         if (launch) begin
            rd_bank_q <= rd_ptr_q;
            rd_geom_q <= geom_q[rd_ptr_q];
         end
         if (drain_end) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign rd_start  = rd_start_q;
   assign rd_bank   = rd_bank_q;
   assign rd_len    = rd_geom_q.len;
   assign rd_offset = rd_geom_q.offset;
   assign busy      = !w_idle || (bank_q[0] != B_EMPTY) || (bank_q[1] != B_EMPTY);

endmodule

// File: tb/tb_intlv_pp_ctrl.sv
// tb_intlv_pp_ctrl: directed and randomized bench for intlv_pp_ctrl with a
// transaction-level reference model of the two banks, writer and reader.
module tb_intlv_pp_ctrl;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [1:0]  pb_type;
   logic        start_rdy;
   logic        din_vld;
   logic        wen;
   logic [11:0] wr_addr;
   logic        wr_bank;
   logic        rd_start;
   logic [11:0] rd_len;
   logic [11:0] rd_offset;
   logic        rd_bank;
   logic        rd_done;
   logic        busy;
   logic        err;

   intlv_pp_ctrl dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .pb_type   (pb_type),
      .start_rdy (start_rdy),
      .din_vld   (din_vld),
      .wen       (wen),
      .wr_addr   (wr_addr),
      .wr_bank   (wr_bank),
      .rd_start  (rd_start),
      .rd_len    (rd_len),
      .rd_offset (rd_offset),
      .rd_bank   (rd_bank),
      .rd_done   (rd_done),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: bank status 0=empty 1=filling 2=full 3=draining.
   int m_bank [2];
   int m_len  [2];
   int m_off  [2];
   int m_wptr, m_rptr, m_cnt, m_rd_age;
   bit m_wr_active, m_rd_active;
   bit e_wen, e_rd_start, e_err;
   int e_addr, e_wbank, e_rd_len, e_rd_off, e_rd_bank;

   // Run bookkeeping (observed from the DUT).
   int cyc = 0;
   int last_dv_cyc = 0;
   int wen_seen = 0;
   int rs_count = 0;
   int rs_cyc = 0;
   logic [31:0] rs_bank = 0;
   bit auto_rd = 0;
   int rd_lat = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int len_of(input int pt);
      case (pt)
         1:       return 544;
         2:       return 2080;
         default: return 64;
      endcase
   endfunction

   function automatic int off_of(input int pt);
      case (pt)
         1:       return 64;
         2:       return 608;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_rdy();
      return !m_wr_active && (m_bank[m_wptr] == 0);
   endfunction

   function automatic bit m_busy();
      return m_wr_active || (m_bank[0] != 0) || (m_bank[1] != 0);
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_bank[b] = 0; m_len[b] = 0; m_off[b] = 0;
      end
      m_wptr = 0; m_rptr = 0; m_cnt = 0; m_rd_age = 0;
      m_wr_active = 0; m_rd_active = 0;
      e_wen = 0; e_rd_start = 0; e_err = 0;
      e_addr = 0; e_wbank = 0; e_rd_len = 0; e_rd_off = 0; e_rd_bank = 0;
   endtask

   // Advance the model across one clock edge; all decisions use pre-edge state.
   task automatic model_step(input bit s, input int pt, input bit dv, input bit rd);
      bit acc, launch, finish, illegal;
      acc     = s && m_rdy();
      launch  = !m_rd_active && (m_bank[m_rptr] == 2);
      finish  = m_rd_active && rd;
      illegal = 0;
`ifdef INTLV_ERR_CHK_EN
      if (acc && pt == 3) begin illegal = 1; e_err = 1; end
      if (dv && !m_wr_active) e_err = 1;
      if (rd && !m_rd_active) e_err = 1;
`endif
      e_wen = 0;
      e_rd_start = 0;
      if (m_wr_active && dv) begin
         e_wen = 1; e_addr = m_cnt; e_wbank = m_wptr;
         m_cnt++;
         if (m_cnt == m_len[m_wptr]) begin
            m_bank[m_wptr] = 2; m_wr_active = 0; m_wptr ^= 1;
         end
      end else if (acc && !illegal) begin
         m_bank[m_wptr] = 1;
         m_len[m_wptr] = len_of(pt);
         m_off[m_wptr] = off_of(pt);
         m_cnt = 0; m_wr_active = 1;
      end
      if (launch) begin
         m_bank[m_rptr] = 3; m_rd_active = 1; m_rd_age = 0;
         e_rd_start = 1; e_rd_len = m_len[m_rptr]; e_rd_off = m_off[m_rptr]; e_rd_bank = m_rptr;
      end else if (finish) begin
         m_bank[m_rptr] = 0; m_rd_active = 0; m_rptr ^= 1;
      end else if (m_rd_active) begin
         m_rd_age++;
      end
   endtask

   task automatic check_outputs(input bit full);
      chk("start_rdy", start_rdy, m_rdy());
      chk("busy", busy, m_busy());
      chk("wen", wen, e_wen);
      if (full || e_wen) begin
         chk("wr_addr", wr_addr, e_addr);
         chk("wr_bank", wr_bank, e_wbank);
      end
      chk("rd_start", rd_start, e_rd_start);
      if (full || m_rd_active) begin
         chk("rd_len", rd_len, e_rd_len);
         chk("rd_offset", rd_offset, e_rd_off);
         chk("rd_bank", rd_bank, e_rd_bank);
      end
      chk("err", err, e_err);
      if (wen === 1'b1) wen_seen++;
      if (rd_start === 1'b1) begin rs_count++; rs_cyc = cyc; rs_bank = rd_bank; end
   endtask

   // One clock cycle; entered and left 1 time unit after a rising edge.
   task automatic cycle(input bit s, input int pt, input bit dv, input bit rd);
      bit rdx;
      rdx = rd | (auto_rd && m_rd_active && (m_rd_age >= rd_lat));
      cyc++;
      start = s; pb_type = pt[1:0]; din_vld = dv; rd_done = rdx;
      @(negedge clk);
      check_outputs(0);
      model_step(s, pt, dv, rdx);
      if (dv) last_dv_cyc = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      n_rst = 1'b0; start = 0; pb_type = 0; din_vld = 0; rd_done = 0;
      #1;
      model_reset();
      check_outputs(1);
      @(posedge clk);
      #1 n_rst = 1'b1;
      @(negedge clk);
      check_outputs(1);
      @(posedge clk);
      #1;
   endtask

   // Request one PB and feed its bits. gap: 0 continuous, 1 one-in-three,
   // 2 random. max_bits < 0 sends the whole PB. done_last pulses rd_done
   // together with the final bit.
   task automatic send_pb(input int pt, input int gap, input bit done_last, input int max_bits);
      int budget, bits, wb;
      budget = 5000;
      while (!m_rdy() && budget > 0) begin
         cycle(0, 0, 0, 0);
         budget--;
      end
      if (budget == 0) begin
         compared++;
         mismatched++;
         $error("FAIL wait_ready: observed timeout expected ready within 5000 cycles");
         return;
      end
      wb = m_wptr;
      cycle(1, pt, 0, 0);
      if (!m_wr_active) return;
      bits = m_len[wb];
      if (max_bits >= 0 && max_bits < bits) bits = max_bits;
      for (int i = 0; i < bits; i++) begin
         cycle(0, 0, 1, done_last && (i == bits - 1));
         if (i != bits - 1) begin
            if (gap == 1) idle(2);
            else if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: observed no completion expected finish before 900000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dcyc;
      n_rst = 1'b1; start = 0; pb_type = 0; din_vld = 0; rd_done = 0;
      #2;
      apply_reset();

      // Single PB16 with continuous bits, no read completion.
      wen_seen = 0; rs_count = 0;
      send_pb(0, 0, 0, -1);
      idle(5);
      chk("pb16_wen_count", wen_seen, 64);
      chk("pb16_rd_start_count", rs_count, 1);
      chk("pb16_rd_start_delay", rs_cyc - last_dv_cyc, 2);
      chk("pb16_rd_bank", rs_bank, 0);

      // PB136 then PB520 back-to-back with no read completion.
      apply_reset();
      send_pb(1, 0, 0, -1);
      send_pb(2, 0, 0, -1);
      idle(6);
      chk("both_full_start_rdy", start_rdy, 0);
      cycle(0, 0, 0, 1);
      idle(2);
      chk("freed_start_rdy", start_rdy, 1);

      // Gapped one-in-three bits on PB136.
      apply_reset();
      wen_seen = 0;
      send_pb(1, 1, 0, -1);
      idle(3);
      chk("gapped_wen_count", wen_seen, 544);

      // Read completion in the same cycle as the last bit into the other bank.
      apply_reset();
      send_pb(0, 0, 0, -1);
      idle(3);
      send_pb(0, 0, 1, -1);
      dcyc = last_dv_cyc;
      idle(4);
      chk("handoff_delay", rs_cyc - dcyc, 2);
      chk("handoff_bank", rs_bank, 1);

      // Illegal PB type.
      apply_reset();
      wen_seen = 0;
      send_pb(3, 0, 0, -1);
      idle(3);
`ifdef INTLV_ERR_CHK_EN
      chk("illegal_err", err, 1);
      chk("illegal_no_claim", busy, 0);
      chk("illegal_no_wen", wen_seen, 0);
`else
      chk("illegal_as_pb16_wen", wen_seen, 64);
      chk("illegal_as_pb16_len", rd_len, 12'h040);
`endif

      // Reset in the middle of a PB520, then a fresh PB16 on bank 0.
      apply_reset();
      send_pb(2, 0, 0, 300);
      apply_reset();
      rs_count = 0;
      send_pb(0, 0, 0, -1);
      idle(4);
      chk("post_reset_rd_start_count", rs_count, 1);
      chk("post_reset_rd_bank", rs_bank, 0);

      // Randomized traffic with an automatic reader of random latency.
      apply_reset();
      auto_rd = 1;
      for (int n = 0; n < 8; n++) begin
         rd_lat = $urandom_range(0, 30);
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            if (!m_rdy() && $urandom_range(0, 1) == 1)
               cycle(1, $urandom_range(0, 3), 0, 0);
            else
               cycle(0, 0, $urandom_range(0, 3) == 0, !m_rd_active && $urandom_range(0, 3) == 0);
         end
         send_pb($urandom_range(0, 3), 2, 0, -1);
      end
      idle(80);
      chk("random_drained_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
